// File: rtl/dpm_pkg.sv
// Shared definitions for the byte serializer: state encoding, defaults, width helper.
package dpm_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_BIT_PERIOD = 1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_period_counter.sv
// Counts clocks within one serial bit; o_tick marks the final cycle of each period.
module bit_period_counter
  import dpm_pkg::*;
#(
  parameter int unsigned PERIOD = DEF_BIT_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CW = clog2_min1(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-PERIOD count, forced to zero by restart or reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign o_tick = (cnt == LAST);

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter with one-word holding register and gap-free back-to-back words.
module byte_serializer
  import dpm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned BIT_PERIOD = DEF_BIT_PERIOD
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_sdata,
  output logic                  o_bit_valid,
  output logic                  o_frame,
  output logic                  o_busy
);

  localparam int unsigned BCW = clog2_min1(DATA_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  state_e                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_full;
  logic [BCW-1:0]        bit_cnt;

  logic                  tick_c;
  logic                  restart_c;
  logic                  accept_c;
  logic                  last_c;
  logic                  load_c;
  logic [DATA_WIDTH-1:0] load_word_c;
  logic                  hold_wr_c;
  logic                  hold_full_nxt_c;
  logic                  shift_nxt_c;

  // Bit that leaves the shifter first for a given word.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
  endfunction

  // Word after removing the bit that was just sent.
  function automatic logic [DATA_WIDTH-1:0] shift_one(input logic [DATA_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  // Counter is parked at zero while idle so a bypass load starts a fresh period.
  assign restart_c = (state == ST_IDLE);

  bit_period_counter #(
    .PERIOD (BIT_PERIOD)
  ) u_period (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_restart (restart_c),
    .o_tick    (tick_c)
  );

  // Decide where a new word comes from and what happens to the holding register.
  always_comb begin
    accept_c        = i_valid & o_ready;
    last_c          = (state == ST_SHIFT) & tick_c & (bit_cnt == LAST_BIT);
    load_c          = 1'b0;
    load_word_c     = i_data;
    hold_wr_c       = 1'b0;
    hold_full_nxt_c = hold_full;
    shift_nxt_c     = (state == ST_SHIFT);
    if (state == ST_IDLE) begin
      if (accept_c) begin
        load_c      = 1'b1;
        shift_nxt_c = 1'b1;
      end
    end else if (last_c) begin
      if (hold_full) begin
        load_c          = 1'b1;
        load_word_c     = hold;
        hold_wr_c       = accept_c;
        hold_full_nxt_c = accept_c;
      end else if (accept_c) begin
        load_c = 1'b1;
      end else begin
        shift_nxt_c = 1'b0;
      end
    end else if (accept_c) begin
      hold_wr_c       = 1'b1;
      hold_full_nxt_c = 1'b1;
    end
  end

  // Shifter FSM, holding register and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      bit_cnt     <= '0;
      o_ready     <= 1'b0;
      o_sdata     <= 1'b0;
      o_bit_valid <= 1'b0;
      o_frame     <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      hold_full <= hold_full_nxt_c;
      o_ready   <= ~hold_full_nxt_c;
      o_busy    <= shift_nxt_c | hold_full_nxt_c;
      if (hold_wr_c) begin
        hold <= i_data;
      end
      if (load_c) begin
        state       <= ST_SHIFT;
        bit_cnt     <= '0;
        shreg       <= shift_one(load_word_c);
        o_sdata     <= first_bit(load_word_c);
        o_bit_valid <= 1'b1;
        o_frame     <= 1'b1;
      end else if (state == ST_SHIFT && tick_c) begin
        if (last_c) begin
          state       <= ST_IDLE;
          bit_cnt     <= '0;
          o_sdata     <= 1'b0;
          o_bit_valid <= 1'b0;
          o_frame     <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + BCW'(1);
          shreg   <= shift_one(shreg);
          o_sdata <= first_bit(shreg);
          o_frame <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Randomised and directed bench for byte_serializer against a word-level timing model.
module tb_byte_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] valid = 2'b00;
  logic [7:0] data [2];
  wire  [1:0] rdy, sd, bv, fr, bsy;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit model_init = 1'b0;

  // Unit 0: defaults (MSB first, 1 clk/bit). Unit 1: LSB first, 3 clk/bit.
  byte_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1), .BIT_PERIOD(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[0]), .i_valid(valid[0]),
    .o_ready(rdy[0]), .o_sdata(sd[0]), .o_bit_valid(bv[0]), .o_frame(fr[0]), .o_busy(bsy[0]));

  byte_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .BIT_PERIOD(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[1]), .i_valid(valid[1]),
    .o_ready(rdy[1]), .o_sdata(sd[1]), .o_bit_valid(bv[1]), .o_frame(fr[1]), .o_busy(bsy[1]));

  always #5 clk = ~clk;

  function automatic int bp(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit msbf(input int i);
    return (i == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- word-level model ----------------
  bit         m_act [2];
  bit         m_pf  [2];
  bit         m_rdy [2];
  int         m_cyc [2];
  logic [7:0] m_word[2];
  logic [7:0] m_pend[2];
  logic [7:0] eq0[$], eq1[$], gq0[$], gq1[$];

  task automatic model_step(input int i);
    bit acc, taken;
    if (!rst_n) begin
      m_act[i] = 0; m_pf[i] = 0; m_rdy[i] = 0; m_cyc[i] = 0;
      return;
    end
    acc = valid[i] && m_rdy[i];
    taken = 0;
    if (m_act[i]) begin
      m_cyc[i]++;
      if (m_cyc[i] == 8 * bp(i)) begin
        if (i == 0) eq0.push_back(m_word[i]); else eq1.push_back(m_word[i]);
        m_cyc[i] = 0;
        if (m_pf[i]) begin m_word[i] = m_pend[i]; m_pf[i] = 0; end
        else if (acc) begin m_word[i] = data[i]; taken = 1; end
        else m_act[i] = 0;
      end
    end else if (acc) begin
      m_act[i] = 1; m_word[i] = data[i]; m_cyc[i] = 0; taken = 1;
    end
    if (acc && !taken) begin m_pend[i] = data[i]; m_pf[i] = 1; end
    m_rdy[i] = !m_pf[i];
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    model_init = 1'b1;
    cyc++;
  end

  // ---------------- compare, decode and monitor ----------------
  int         dcnt[2];
  logic [7:0] dword[2];
  int         run_len[2];
  int         max_run[2];
  int         frame_t[$];
  logic       e_sd;
  logic [7:0] e_w;
  int         e_k;

  always @(negedge clk) begin
    if (model_init) begin
      for (int i = 0; i < 2; i++) begin
        e_w  = m_word[i];
        e_k  = m_cyc[i] / bp(i);
        e_sd = m_act[i] ? e_w[msbf(i) ? 7 - e_k : e_k] : 1'b0;
        chk($sformatf("u%0d sdata", i), 32'(sd[i]), 32'(e_sd));
        chk($sformatf("u%0d bit_valid", i), 32'(bv[i]), 32'(m_act[i]));
        chk($sformatf("u%0d frame", i), 32'(fr[i]), 32'(m_act[i] && m_cyc[i] < bp(i)));
        chk($sformatf("u%0d busy", i), 32'(bsy[i]), 32'(m_act[i] || m_pf[i]));
        chk($sformatf("u%0d ready", i), 32'(rdy[i]), 32'(m_rdy[i]));
        if (bv[i] !== 1'b1) begin
          dcnt[i] = 0; run_len[i] = 0;
        end else begin
          run_len[i]++;
          if (run_len[i] > max_run[i]) max_run[i] = run_len[i];
          if (dcnt[i] % bp(i) == 0) begin
            e_k = dcnt[i] / bp(i);
            dword[i][msbf(i) ? 7 - e_k : e_k] = sd[i];
          end
          dcnt[i]++;
          if (dcnt[i] == 8 * bp(i)) begin
            if (i == 0) gq0.push_back(dword[i]); else gq1.push_back(dword[i]);
            dcnt[i] = 0;
          end
        end
      end
      if (fr[0] === 1'b1) frame_t.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers (called #1 after a rising edge) ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input int i, input logic [7:0] w, input bit keep);
    int n = 0;
    data[i] = w; valid[i] = 1'b1;
    while (rdy[i] !== 1'b1 && n < 300) begin step(); n++; end
    if (rdy[i] !== 1'b1) chk($sformatf("u%0d ready wait", i), 32'(rdy[i]), 32'd1);
    step();
    if (!keep) valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while ((bsy[i] !== 1'b0 || bv[i] !== 1'b0) && n < 600) begin step(); n++; end
    chk($sformatf("u%0d idle wait", i), 32'(bsy[i]), 32'd0);
  endtask

  logic exp_a5 [8];
  logic exp_81 [8];
  int   snap, snap2, found;

  initial begin
    data[0] = 8'h00; data[1] = 8'h00;
    exp_a5 = '{1, 0, 1, 0, 0, 1, 0, 1};
    exp_81 = '{1, 0, 0, 0, 0, 0, 0, 1};

    // Reset held: everything low, ready low.
    repeat (3) step();
    chk("rst ready", 32'(rdy), 32'd0);
    chk("rst busy", 32'(bsy), 32'd0);
    chk("rst outs", 32'({sd, bv, fr}), 32'd0);
    rst_n = 1'b1;
    step();
    chk("ready after release", 32'(rdy), 32'd3);

    // Single A5, MSB first: 1,0,1,0,0,1,0,1 then idle.
    send(0, 8'hA5, 0);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("A5 bit%0d", j), 32'(sd[0]), 32'(exp_a5[j]));
      chk($sformatf("A5 frame%0d", j), 32'(fr[0]), 32'(j == 0));
      step();
    end
    chk("A5 end bit_valid", 32'(bv[0]), 32'd0);
    chk("A5 end sdata", 32'(sd[0]), 32'd0);

    // Held valid with 01,02,04: 24 contiguous bits, frames 8 apart, ready low while hold full.
    max_run[0] = 0; frame_t.delete();
    send(0, 8'h01, 1);
    send(0, 8'h02, 1);
    chk("hold full ready", 32'(rdy[0]), 32'd0);
    chk("hold full busy", 32'(bsy[0]), 32'd1);
    send(0, 8'h04, 0);
    wait_idle(0);
    chk("burst run", 32'(max_run[0]), 32'd24);
    chk("frame count", 32'(frame_t.size()), 32'd3);
    if (frame_t.size() == 3) begin
      chk("frame gap1", 32'(frame_t[1] - frame_t[0]), 32'd8);
      chk("frame gap2", 32'(frame_t[2] - frame_t[1]), 32'd8);
    end

    // 81 on LSB-first, 3 clk/bit unit.
    max_run[1] = 0;
    send(1, 8'h81, 0);
    for (int j = 0; j < 24; j++) begin
      chk($sformatf("81 c%0d", j), 32'(sd[1]), 32'(exp_81[j / 3]));
      step();
    end
    chk("81 end bit_valid", 32'(bv[1]), 32'd0);
    chk("81 run", 32'(max_run[1]), 32'd24);

    // FF offered only while ready is low must be dropped.
    send(0, 8'h11, 1);
    send(0, 8'h22, 0);
    data[0] = 8'hFF; valid[0] = 1'b1;
    for (int n = 0; n < 50 && rdy[0] !== 1'b1; n++) step();
    valid[0] = 1'b0;
    wait_idle(0);
    chk("drop last word", 32'(gq0[gq0.size() - 1]), 32'h22);
    chk("drop prev word", 32'(gq0[gq0.size() - 2]), 32'h11);

    // Reset at bit 4 of 3C with C3 held: abort, discard.
    send(0, 8'h3C, 0);
    send(0, 8'hC3, 0);
    repeat (3) step();
    chk("3C at bit4 frame", 32'(fr[0]), 32'd0);
    chk("3C at bit4 busy", 32'(bsy[0]), 32'd1);
    rst_n = 1'b0;
    step();
    chk("mid rst outs", 32'({sd[0], bv[0], fr[0], bsy[0], rdy[0]}), 32'd0);
    snap = gq0.size();
    rst_n = 1'b1;
    step();
    chk("mid rst ready", 32'(rdy[0]), 32'd1);
    repeat (30) begin
      chk("post rst quiet", 32'(bv[0]), 32'd0);
      step();
    end

    // Walking-one generator, valid held: 16 words, 128 gap-free bits.
    max_run[0] = 0;
    for (int k = 0; k < 16; k++) send(0, 8'(1 << (k % 8)), k != 15);
    wait_idle(0);
    chk("walk run", 32'(max_run[0]), 32'd128);
    chk("walk count", 32'(gq0.size() - snap), 32'd16);
    for (int k = 0; k < 16 && snap + k < gq0.size(); k++)
      chk($sformatf("walk w%0d", k), 32'(gq0[snap + k]), 32'(1 << (k % 8)));
    snap2 = gq0.size();
    found = 0;
    for (int k = snap; k < snap2; k++) if (gq0[k] == 8'hC3) found++;
    chk("C3 never emitted", 32'(found), 32'd0);

    // Random traffic on both units with one reset pulse.
    for (int n = 0; n < 1500; n++) begin
      valid[0] = ($urandom_range(0, 3) != 0);
      valid[1] = ($urandom_range(0, 1) != 0);
      data[0] = 8'($urandom);
      data[1] = 8'($urandom);
      rst_n = !(n == 700 || n == 701);
      step();
    end
    valid = 2'b00; rst_n = 1'b1;
    wait_idle(0);
    wait_idle(1);
    step();

    // Decoded serial stream against words the model completed.
    chk("u0 word count", 32'(gq0.size()), 32'(eq0.size()));
    chk("u1 word count", 32'(gq1.size()), 32'(eq1.size()));
    for (int k = 0; k < gq0.size() && k < eq0.size(); k++)
      chk($sformatf("u0 word%0d", k), 32'(gq0[k]), 32'(eq0[k]));
    for (int k = 0; k < gq1.size() && k < eq1.size(); k++)
      chk($sformatf("u1 word%0d", k), 32'(gq1[k]), 32'(eq1[k]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
